// File: rtl/clock_div_multi.sv
// Multi-channel programmable divider: per channel toggle / tick / one-shot output from a runtime divisor.
// Outputs are registered; an event on edge N is visible after edge N. Config port accepts at most one
// write every two cycles (cfg_ready low for the commit cycle after each accept).
module clock_div_multi #(
    parameter int CHANNELS     = 4,
    parameter int CNT_W        = 28,
    parameter int DEFAULT_DIV  = 2000000,
    parameter int DEFAULT_MODE = 1,
    localparam int CHAN_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                sync,
    input  logic [CHANNELS-1:0] ch_en,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CHAN_W-1:0]   cfg_chan,
    input  logic [CNT_W-1:0]    cfg_div,
    input  logic [1:0]          cfg_mode,
    output logic                cfg_err,
    output logic [CHANNELS-1:0] slow_clock,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] done
);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_TOGGLE  = 2'd1,
        MODE_TICK    = 2'd2,
        MODE_ONESHOT = 2'd3
    } mode_e;

    logic [CNT_W-1:0]    div_q   [CHANNELS];
    logic [CNT_W-1:0]    div_d   [CHANNELS];
    mode_e               mode_q  [CHANNELS];
    mode_e               mode_d  [CHANNELS];
    logic [CNT_W-1:0]    count_q [CHANNELS];
    logic [CNT_W-1:0]    count_d [CHANNELS];
    logic [CHANNELS-1:0] slow_q, slow_d;
    logic [CHANNELS-1:0] tick_q, tick_d;
    logic [CHANNELS-1:0] done_q, done_d;
    logic                cfg_ready_q, cfg_ready_d;
    logic                cfg_err_q, cfg_err_d;

    logic                accept;
    logic                chan_bad;
    logic [CHANNELS-1:0] hit;
    logic [CHANNELS-1:0] wrap;

    always_comb begin
        accept      = cfg_valid && cfg_ready_q;
        chan_bad    = int'(cfg_chan) >= CHANNELS;
        cfg_ready_d = !accept;
        cfg_err_d   = accept && chan_bad;
        hit         = '0;
        wrap        = '0;
        div_d       = div_q;
        mode_d      = mode_q;
        count_d     = count_q;
        slow_d      = slow_q;
        tick_d      = '0;
        done_d      = done_q;

        for (int i = 0; i < CHANNELS; i++) begin
            hit[i]  = accept && !chan_bad && (int'(cfg_chan) == i);
            // count never passes div, so the +1 below cannot overflow
            wrap[i] = (count_q[i] == div_q[i]);

            if (hit[i]) begin
                div_d[i]  = cfg_div;
                mode_d[i] = mode_e'(cfg_mode);
            end

            if (sync || hit[i]) begin
                count_d[i] = '0;
                slow_d[i]  = 1'b0;
                done_d[i]  = 1'b0;
            end else if (ch_en[i]) begin
                case (mode_q[i])
                    MODE_TOGGLE: begin
                        count_d[i] = wrap[i] ? '0 : count_q[i] + 1'b1;
                        if (wrap[i]) begin
                            slow_d[i] = !slow_q[i];
                        end
                    end
                    MODE_TICK: begin
                        count_d[i] = wrap[i] ? '0 : count_q[i] + 1'b1;
                        slow_d[i]  = 1'b0;
                        tick_d[i]  = wrap[i];
                    end
                    MODE_ONESHOT: begin
                        slow_d[i] = 1'b0;
                        if (done_q[i]) begin
                            count_d[i] = '0;
                        end else begin
                            count_d[i] = wrap[i] ? '0 : count_q[i] + 1'b1;
                            tick_d[i]  = wrap[i];
                            done_d[i]  = wrap[i];
                        end
                    end
                    default: begin
                        count_d[i] = '0;
                        slow_d[i]  = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                div_q[i]   <= CNT_W'(DEFAULT_DIV);
                mode_q[i]  <= mode_e'(2'(DEFAULT_MODE));
                count_q[i] <= '0;
            end
            slow_q      <= '0;
            tick_q      <= '0;
            done_q      <= '0;
            cfg_ready_q <= 1'b1;
            cfg_err_q   <= 1'b0;
        end else begin
            div_q       <= div_d;
            mode_q      <= mode_d;
            count_q     <= count_d;
            slow_q      <= slow_d;
            tick_q      <= tick_d;
            done_q      <= done_d;
            cfg_ready_q <= cfg_ready_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign cfg_ready  = cfg_ready_q;
    assign cfg_err    = cfg_err_q;
    assign slow_clock = slow_q;
    assign tick       = tick_q;
    assign done       = done_q;

endmodule

// File: tb/tb_clock_div_multi.sv
// Directed bench for clock_div_multi with 3 channels, so that index 3 is an out-of-range channel.
module tb_clock_div_multi;

    localparam int CH  = 3;
    localparam int CW  = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          sync;
    logic [CH-1:0] ch_en;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_chan;
    logic [CW-1:0] cfg_div;
    logic [1:0]    cfg_mode;
    logic          cfg_err;
    logic [CH-1:0] slow_clock;
    logic [CH-1:0] tick;
    logic [CH-1:0] done;

    int passed = 0;
    int total  = 0;

    clock_div_multi #(
        .CHANNELS    (CH),
        .CNT_W       (CW),
        .DEFAULT_DIV (3),
        .DEFAULT_MODE(1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .sync      (sync),
        .ch_en     (ch_en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_div   (cfg_div),
        .cfg_mode  (cfg_mode),
        .cfg_err   (cfg_err),
        .slow_clock(slow_clock),
        .tick      (tick),
        .done      (done)
    );

    always #5 clock = !clock;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Accept on the first step, commit cycle on the second: returns after one edge of new config.
    task automatic write(input logic [1:0] chan, input logic [CW-1:0] dv, input logic [1:0] md);
        cfg_valid = 1'b1;
        cfg_chan  = chan;
        cfg_div   = dv;
        cfg_mode  = md;
        step();
        cfg_valid = 1'b0;
        step();
    endtask

    initial begin
        logic [CH-1:0] exp_slow;
        reset     = 1'b1;
        sync      = 1'b0;
        ch_en     = '0;
        cfg_valid = 1'b0;
        cfg_chan  = '0;
        cfg_div   = '0;
        cfg_mode  = '0;
        step();
        step();
        chk("rst_slow", 32'(slow_clock), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ready", 32'(cfg_ready), 1);
        chk("rst_err", 32'(cfg_err), 0);

        // Defaults D=3 toggle: rises on 4th edge, period 8.
        reset = 1'b0;
        ch_en = '1;
        for (int k = 1; k <= 16; k++) begin
            step();
            exp_slow = ((k / 4) % 2 == 1) ? '1 : '0;
            chk($sformatf("dflt_toggle_k%0d", k), 32'(slow_clock), 32'(exp_slow));
        end

        // ch1 D=4 tick mode.
        cfg_valid = 1'b1;
        cfg_chan  = 2'd1;
        cfg_div   = 8'd4;
        cfg_mode  = 2'd2;
        step();
        chk("tick_ready_low", 32'(cfg_ready), 0);
        cfg_valid = 1'b0;
        for (int j = 1; j <= 15; j++) begin
            step();
            chk($sformatf("tick1_j%0d", j), 32'(tick[1]), (j % 5 == 0) ? 1 : 0);
            chk($sformatf("tick1_slow_j%0d", j), 32'(slow_clock[1]), 0);
            if (j == 1) chk("tick_ready_back", 32'(cfg_ready), 1);
        end

        // ch2 D=2 one-shot: single tick on 3rd edge after commit.
        write(2'd2, 8'd2, 2'd3);
        chk("os_j1_tick", 32'(tick[2]), 0);
        for (int j = 2; j <= 10; j++) begin
            step();
            chk($sformatf("os_tick_j%0d", j), 32'(tick[2]), (j == 3) ? 1 : 0);
            chk($sformatf("os_done_j%0d", j), 32'(done[2]), (j >= 3) ? 1 : 0);
            chk($sformatf("os_slow_j%0d", j), 32'(slow_clock[2]), 0);
        end

        // ch0 restarted D=3 toggle, paused with count=1 and slow=1.
        write(2'd0, 8'd3, 2'd1);
        for (int j = 2; j <= 5; j++) step();
        chk("pause_pre", 32'(slow_clock[0]), 1);
        ch_en = 3'b100;
        for (int j = 1; j <= 10; j++) begin
            step();
            chk($sformatf("pause_slow_j%0d", j), 32'(slow_clock[0]), 1);
            chk($sformatf("pause_tick_j%0d", j), 32'(tick[1]), 0);
        end
        ch_en = '1;
        step();
        chk("resume_r1", 32'(slow_clock[0]), 1);
        step();
        chk("resume_r2", 32'(slow_clock[0]), 1);
        step();
        chk("resume_r3", 32'(slow_clock[0]), 0);
        chk("os_done_held", 32'(done[2]), 1);

        // D=1,2,5 toggling, then sync realigns everything.
        write(2'd0, 8'd1, 2'd1);
        write(2'd1, 8'd2, 2'd1);
        write(2'd2, 8'd5, 2'd1);
        chk("rewrite_done_clr", 32'(done[2]), 0);
        for (int j = 0; j < 7; j++) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("sync_slow_zero", 32'(slow_clock), 0);
        for (int j = 1; j <= 24; j++) begin
            step();
            exp_slow[0] = ((j / 2) % 2) == 1;
            exp_slow[1] = ((j / 3) % 2) == 1;
            exp_slow[2] = ((j / 6) % 2) == 1;
            chk($sformatf("sync_slow_j%0d", j), 32'(slow_clock), 32'(exp_slow));
            if (j == 13) begin
                chk("bad_err_pulse", 32'(cfg_err), 1);
                chk("bad_ready_low", 32'(cfg_ready), 0);
                cfg_valid = 1'b0;
            end
            if (j == 14) chk("bad_err_clear", 32'(cfg_err), 0);
            if (j == 12) begin
                cfg_valid = 1'b1;
                cfg_chan  = 2'd3;
                cfg_div   = 8'd0;
                cfg_mode  = 2'd0;
            end
        end

        // ch1 D=0 tick: held high continuously.
        write(2'd1, 8'd0, 2'd2);
        chk("d0_tick_j1", 32'(tick[1]), 1);
        for (int j = 2; j <= 7; j++) begin
            step();
            chk($sformatf("d0_tick_j%0d", j), 32'(tick[1]), 1);
        end
        chk("d0_err_quiet", 32'(cfg_err), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
